// File: rtl/prbs_check.sv
// ---------------------------------------------------------------------------
// prbs_check -- registered PRBS / scrambler-sequence checker
//
// Sits downstream of a PRBS generator path (after serdes or loopback) and
// checks the received words against the sequence they carry. The checker
// runs a Fibonacci LFSR in feed-forward mode: its history register is loaded
// from the received bits, not from its own feedback. Any clean stretch of
// LFSR_WIDTH received bits therefore resynchronises it without any seeding.
//
// Outputs are a per-bit error mask and a HUNT/LOCKED lock indication. A
// saturating bit-error counter runs only while locked.
//
// Build option:
//   PRBS_CHECK_WORD_CNT_EN -- when defined, word_count counts valid words
//   checked while locked. When undefined, word_count is tied to zero and no
//   counter is built.
//
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset
//   data_in          received PRBS word (first bit in time at the MSB when
//                    REVERSE=0)
//   data_in_valid    data_in qualifier; every valid word is accepted
//   err_count_clear  synchronous clear of err_count (and word_count)
//   error_out        registered per-bit mismatch mask of the last accepted
//                    word
//   error_valid      error_out qualifier (data_in_valid delayed one cycle)
//   locked           checker locked to the sequence
//   lock_lost        one-cycle pulse when LOCKED drops back to HUNT
//   err_count        saturating count of bit errors seen while locked
//   word_count       saturating count of words checked while locked
//                    (zero unless the build option is enabled)
//
// The file also holds the combinational parallel LFSR used by the checker.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// lfsr -- combinational parallel LFSR step
//
// Advances an LFSR by DATA_WIDTH bit-times in one step, with data_in mixed
// into the feedback. Bits are taken MSB first (REVERSE=0) or LSB first
// (REVERSE=1). REVERSE also reverses the bit order of state_in/state_out.
//
// LFSR_POLY lists the feedback taps: bit j set means the tap is x^j. The top
// term x^LFSR_WIDTH is implied.
//   FIBONACCI: the feedback is the oldest state bit XOR the tapped state
//              bits XOR the data bit. That feedback is the output bit. The
//              register shifts in the feedback, or only the data bit when
//              LFSR_FEED_FORWARD=1, which makes it a self-synchronising
//              descrambler/checker.
//   GALOIS:    the feedback is XORed into the tapped register positions as
//              the register shifts.
//
// Ports:
//   data_in    DATA_WIDTH bits mixed into the sequence
//   state_in   current LFSR state
//   data_out   DATA_WIDTH feedback bits, one per data bit
//   state_out  LFSR state after DATA_WIDTH bit-times
// ---------------------------------------------------------------------------
module lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 32
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

  // Vectors in processing order: index DATA_WIDTH-1 is handled first.
  logic [DATA_WIDTH-1:0] din_ord;
  logic [DATA_WIDTH-1:0] dout_ord;
  logic [LFSR_WIDTH-1:0] sin_ord;
  logic [LFSR_WIDTH-1:0] sout_ord;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_ord
      if (REVERSE) begin : g_rev
        assign din_ord[gi]  = data_in[DATA_WIDTH-1-gi];
        assign data_out[gi] = dout_ord[DATA_WIDTH-1-gi];
      end else begin : g_fwd
        assign din_ord[gi]  = data_in[gi];
        assign data_out[gi] = dout_ord[gi];
      end
    end

    for (genvar gi = 0; gi < LFSR_WIDTH; gi++) begin : g_state_ord
      if (REVERSE) begin : g_rev
        assign sin_ord[gi]   = state_in[LFSR_WIDTH-1-gi];
        assign state_out[gi] = sout_ord[LFSR_WIDTH-1-gi];
      end else begin : g_fwd
        assign sin_ord[gi]   = state_in[gi];
        assign state_out[gi] = sout_ord[gi];
      end
    end
  endgenerate

  // Bit-serial reference unrolled over the word; synthesis flattens it into
  // an XOR network. st[0] holds the newest bit and st[LFSR_WIDTH-1] the
  // oldest.
  always_comb begin
    logic [LFSR_WIDTH-1:0] st;
    logic                  fb;
    logic                  inj;
    st       = sin_ord;
    dout_ord = '0;
    fb       = 1'b0;
    inj      = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = st[LFSR_WIDTH-1] ^ din_ord[i];
      if (GALOIS) begin
        inj = LFSR_FEED_FORWARD ? din_ord[i] : fb;
        for (int j = LFSR_WIDTH - 1; j > 0; j--) begin
          st[j] = st[j-1] ^ (LFSR_POLY[j] & inj);
        end
        st[0] = inj;
      end else begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) begin
            fb = fb ^ st[j-1];
          end
        end
        inj = LFSR_FEED_FORWARD ? din_ord[i] : fb;
        st  = {st[LFSR_WIDTH-2:0], inj};
      end
      dout_ord[i] = fb;
    end
    sout_ord = st;
  end

endmodule

// ---------------------------------------------------------------------------
// prbs_check top
// ---------------------------------------------------------------------------
module prbs_check #(
  parameter int                    LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
  parameter bit                    LFSR_INVERT   = 1'b1,
  parameter bit                    REVERSE       = 1'b0,
  parameter int                    DATA_WIDTH    = 32,   // must be >= LFSR_WIDTH
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    UNLOCK_COUNT  = 4,
  parameter int                    ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_valid,
  input  logic                     err_count_clear,
  output logic [DATA_WIDTH-1:0]    error_out,
  output logic                     error_valid,
  output logic                     locked,
  output logic                     lock_lost,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [31:0]              word_count
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W = $clog2(UNLOCK_COUNT + 1);
  // Sum width: enough for the counter plus one word's popcount. A narrow
  // counter may be smaller than the popcount itself.
  localparam int SUM_W = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_CNT_WIDTH{1'b1}});

  // Datapath
  logic [DATA_WIDTH-1:0]    word_d;
  logic [DATA_WIDTH-1:0]    err_mask;
  logic [LFSR_WIDTH-1:0]    lfsr_state_reg;
  logic [LFSR_WIDTH-1:0]    lfsr_state_next;
  logic                     word_clean;
  logic [PC_W-1:0]          err_pop;

  // Control
  state_t                   state_reg;
  state_t                   state_next;
  logic [RUN_W-1:0]         run_reg;
  logic [RUN_W-1:0]         run_next;
  logic [BAD_W-1:0]         bad_reg;
  logic [BAD_W-1:0]         bad_next;
  logic                     lock_lost_next;
  logic                     word_counted;

  // Output registers
  logic [DATA_WIDTH-1:0]    error_out_reg;
  logic                     error_valid_reg;
  logic                     lock_lost_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_next;
  logic [SUM_W-1:0]         err_sum;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_err(input logic [SUM_W-1:0] v);
    return (v > ERR_MAX) ? ERR_MAX[ERR_CNT_WIDTH-1:0] : v[ERR_CNT_WIDTH-1:0];
  endfunction

  // Undo the transmit inversion so that a correct stream descrambles to 0.
  assign word_d = data_in ^ {DATA_WIDTH{LFSR_INVERT}};

  // Feed-forward Fibonacci: the error mask is each received bit XOR its
  // polynomial taps. The history register is refilled from the received
  // bits, so after one clean word the check is self-aligned.
  lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       ("FIBONACCI"),
    .LFSR_FEED_FORWARD (1'b1),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH)
  ) u_lfsr (
    .data_in   (word_d),
    .state_in  (lfsr_state_reg),
    .data_out  (err_mask),
    .state_out (lfsr_state_next)
  );

  assign word_clean = (err_mask == '0);

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      err_pop = err_pop + PC_W'(err_mask[i]);
    end
  end

  // Counting follows the state the word was accepted in. The word that
  // drops lock is therefore still counted.
  assign word_counted = data_in_valid && (state_reg == LOCKED);

  // Lock state machine: next state and run counters
  always_comb begin
    state_next     = state_reg;
    run_next       = run_reg;
    bad_next       = bad_reg;
    lock_lost_next = 1'b0;
    if (data_in_valid) begin
      case (state_reg)
        HUNT: begin
          if (word_clean) begin
            if (run_reg == RUN_W'(LOCK_COUNT - 1)) begin
              state_next = LOCKED;
              run_next   = '0;
            end else begin
              run_next = run_reg + 1'b1;
            end
          end else begin
            run_next = '0;
          end
        end
        LOCKED: begin
          if (!word_clean) begin
            if (bad_reg == BAD_W'(UNLOCK_COUNT - 1)) begin
              state_next     = HUNT;
              bad_next       = '0;
              run_next       = '0;
              lock_lost_next = 1'b1;
            end else begin
              bad_next = bad_reg + 1'b1;
            end
          end else begin
            bad_next = '0;
          end
        end
        default: begin
          state_next = HUNT;
          run_next   = '0;
          bad_next   = '0;
        end
      endcase
    end
  end

  // Saturating error counter. A clear in the same cycle as a counted word
  // restarts the count from that word instead of dropping it.
  always_comb begin
    err_sum        = SUM_W'(err_count_reg) + SUM_W'(err_pop);
    err_count_next = err_count_reg;
    if (err_count_clear) begin
      err_count_next = word_counted ? sat_err(SUM_W'(err_pop)) : '0;
    end else if (word_counted) begin
      err_count_next = sat_err(err_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      run_reg         <= '0;
      bad_reg         <= '0;
      lfsr_state_reg  <= '0;
      error_out_reg   <= '0;
      error_valid_reg <= 1'b0;
      lock_lost_reg   <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      run_reg         <= run_next;
      bad_reg         <= bad_next;
      lock_lost_reg   <= lock_lost_next;
      err_count_reg   <= err_count_next;
      error_valid_reg <= data_in_valid;
      if (data_in_valid) begin
        lfsr_state_reg <= lfsr_state_next;
        error_out_reg  <= err_mask;
      end
    end
  end

  assign error_out   = error_out_reg;
  assign error_valid = error_valid_reg;
  assign locked      = (state_reg == LOCKED);
  assign lock_lost   = lock_lost_reg;
  assign err_count   = err_count_reg;

`ifdef PRBS_CHECK_WORD_CNT_EN
  logic [31:0] word_count_reg;
  logic [31:0] word_count_next;

  always_comb begin
    word_count_next = word_count_reg;
    if (err_count_clear) begin
      word_count_next = word_counted ? 32'd1 : 32'd0;
    end else if (word_counted && (word_count_reg != 32'hFFFF_FFFF)) begin
      word_count_next = word_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count_reg <= '0;
    end else begin
      word_count_reg <= word_count_next;
    end
  end

  assign word_count = word_count_reg;
`else
  assign word_count = 32'd0;
`endif

endmodule

// File: tb/tb_prbs_check.sv
// Bench for prbs_check. Two instances share the stimulus: one uses the
// default 32-bit error counter and one uses a 4-bit counter, so that
// saturation is reachable. The reference model works on the bit stream: a
// PRBS31 bit is correct when it equals the XOR of the bits 31 and 28
// positions earlier.
module tb_prbs_check;

  localparam int LOCK_COUNT   = 16;
  localparam int UNLOCK_COUNT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        err_count_clear;

  logic [31:0] error_out,   error_out4;
  logic        error_valid, error_valid4;
  logic        locked,      locked4;
  logic        lock_lost,   lock_lost4;
  logic [31:0] err_count;
  logic [3:0]  err_count4;
  logic [31:0] word_count,  word_count4;

  prbs_check dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .err_count_clear(err_count_clear), .error_out(error_out),
    .error_valid(error_valid), .locked(locked), .lock_lost(lock_lost),
    .err_count(err_count), .word_count(word_count)
  );

  prbs_check #(.ERR_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .err_count_clear(err_count_clear), .error_out(error_out4),
    .error_valid(error_valid4), .locked(locked4), .lock_lost(lock_lost4),
    .err_count(err_count4), .word_count(word_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          hist[$];     // last 31 received (de-inverted) bits, [0] = oldest
  bit          gen[$];      // generator history, same layout
  bit          m_locked, m_lost, m_ev;
  logic [31:0] m_eout;
  int          run_cnt, bad_cnt;
  longint      tot_err, tot_words;   // totals since the last clear/reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint satv(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (31) hist.push_back(1'b0);
    m_locked = 0; m_lost = 0; m_ev = 0; m_eout = '0;
    run_cnt = 0; bad_cnt = 0; tot_err = 0; tot_words = 0;
  endtask

  task automatic model_mask(input logic [31:0] d, output logic [31:0] e);
    bit b;
    for (int i = 31; i >= 0; i--) begin
      b    = d[i];
      e[i] = b ^ hist[0] ^ hist[3];
      hist.push_back(b);
      void'(hist.pop_front());
    end
  endtask

  task automatic model_update(input logic v, input logic [31:0] din, input logic clr);
    logic [31:0] e;
    bit          counted;
    int          n;
    counted = 0; m_lost = 0; n = 0;
    if (v) begin
      model_mask(din ^ 32'hFFFF_FFFF, e);
      m_eout = e; m_ev = 1; n = $countones(e);
      if (m_locked) begin
        counted = 1;
        if (e != 0) begin
          bad_cnt++;
          if (bad_cnt == UNLOCK_COUNT) begin
            m_locked = 0; bad_cnt = 0; run_cnt = 0; m_lost = 1;
          end
        end else bad_cnt = 0;
      end else begin
        if (e == 0) begin
          run_cnt++;
          if (run_cnt == LOCK_COUNT) begin m_locked = 1; run_cnt = 0; end
        end else run_cnt = 0;
      end
    end else begin
      m_ev = 0;
    end
    if (clr) begin
      tot_err   = counted ? longint'(n) : 0;
      tot_words = counted ? 1 : 0;
    end else if (counted) begin
      tot_err   += n;
      tot_words += 1;
    end
  endtask

  task automatic compare_all();
    chk("error_valid",  error_valid,  m_ev);
    chk("error_out",    error_out,    m_eout);
    chk("locked",       locked,       m_locked);
    chk("lock_lost",    lock_lost,    m_lost);
    chk("err_count",    err_count,    satv(tot_err, 32));
    chk("error_out_w4", error_out4,   m_eout);
    chk("error_valid_w4", error_valid4, m_ev);
    chk("locked_w4",    locked4,      m_locked);
    chk("lock_lost_w4", lock_lost4,   m_lost);
    chk("err_count_w4", err_count4,   satv(tot_err, 4));
`ifdef PRBS_CHECK_WORD_CNT_EN
    chk("word_count",    word_count,  satv(tot_words, 32));
    chk("word_count_w4", word_count4, satv(tot_words, 32));
`else
    chk("word_count",    word_count,  0);
    chk("word_count_w4", word_count4, 0);
`endif
  endtask

  // One clock: drive on the falling edge, update the model with what the
  // rising edge accepts, compare just after it.
  task automatic step(input logic v, input logic [31:0] din, input logic clr);
    @(negedge clk);
    data_in_valid = v; data_in = din; err_count_clear = clr;
    @(posedge clk);
    model_update(v, din, clr);
    #1;
    compare_all();
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic areset();
    @(negedge clk);
    data_in_valid = 1'b0; err_count_clear = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_error_out",   error_out,   0);
    chk("rst_error_valid", error_valid, 0);
    chk("rst_locked",      locked,      0);
    chk("rst_lock_lost",   lock_lost,   0);
    chk("rst_err_count",   err_count,   0);
    chk("rst_err_count_w4", err_count4, 0);
    chk("rst_word_count",  word_count,  0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    model_update(1'b0, data_in, 1'b0);
    #1;
    compare_all();
  endtask

  task automatic gen_seed();
    gen.delete();
    for (int i = 0; i < 31; i++) gen.push_back(bit'($urandom_range(0, 1)));
    gen[0] = 1'b1;
  endtask

  // Next raw PRBS31 word, first bit in time at the MSB.
  task automatic gen_word(output logic [31:0] w);
    bit nb;
    for (int i = 31; i >= 0; i--) begin
      nb   = gen[0] ^ gen[3];
      w[i] = nb;
      gen.push_back(nb);
      void'(gen.pop_front());
    end
  endtask

  initial begin
    logic [31:0] w;
    int          bitpos;
    rst = 1'b0; data_in = '0; data_in_valid = 1'b0; err_count_clear = 1'b0;
    model_reset();
    #2;
    areset();

    // A single leading 1 against empty history: it also shows up at its
    // taps 28 and 31 bits later.
    step(1'b1, 32'h7FFF_FFFF, 1'b0);
    chk("first_mask", error_out, 32'h8000_0009);
    chk("model_first_mask", m_eout, 32'h8000_0009);

    // Clean stream of 40 words: lock by word 17, no counted errors.
    areset();
    gen_seed();
    for (int i = 1; i <= 40; i++) begin
      gen_word(w);
      step(1'b1, ~w, 1'b0);
      if (i == 17) chk("lock_by_word17", locked, 1);
    end
    chk("clean_err_count", err_count, 0);

    // Single bit flip at bit 5: taps land in the next word at bits 9 and 6.
    gen_word(w);
    step(1'b1, ~w ^ 32'h0000_0020, 1'b0);
    chk("flip_mask", error_out, 32'h0000_0020);
    gen_word(w);
    step(1'b1, ~w, 1'b0);
    chk("flip_tap_mask", error_out, 32'h0000_0240);
    chk("flip_err_count", err_count, 3);
    chk("flip_locked", locked, 1);
    gen_word(w);
    step(1'b1, ~w, 1'b0);

    // Four all-zero words drop lock on the fourth.
    for (int k = 1; k <= 4; k++) begin
      gen_word(w);
      step(1'b1, 32'h0, 1'b0);
    end
    chk("unlock_pulse", lock_lost, 1);
    chk("unlock_locked", locked, 0);
    for (int i = 1; i <= 17; i++) begin
      gen_word(w);
      step(1'b1, ~w, 1'b0);
    end
    chk("relock", locked, 1);
    chk("relock_pulse_gone", lock_lost, 0);

    // Ten-cycle valid gap, then resume.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, $urandom, 1'b0);
      chk("gap_error_valid", error_valid, 0);
    end
    for (int i = 0; i < 20; i++) begin
      gen_word(w);
      step(1'b1, ~w, 1'b0);
    end
    chk("gap_locked", locked, 1);
    chk("gap_clean", error_out, 0);

    // Twenty single-bit errors, each followed by two normal words.
    for (int k = 0; k < 20; k++) begin
      bitpos = int'($urandom_range(0, 31));
      gen_word(w);
      step(1'b1, ~w ^ (32'h1 << bitpos), 1'b0);
      for (int j = 0; j < 2; j++) begin
        gen_word(w);
        step(1'b1, ~w, 1'b0);
      end
    end
    chk("sat_w4", err_count4, 4'hF);
    chk("sat_locked", locked, 1);

    // Clear with a simultaneous 3-error word; its 6 tap errors follow.
    gen_word(w);
    step(1'b1, ~w ^ 32'h0010_0420, 1'b1);
    chk("clear_mask", error_out, 32'h0010_0420);
    chk("clear_err_count", err_count, 3);
    chk("clear_err_count_w4", err_count4, 3);
    gen_word(w);
    step(1'b1, ~w, 1'b0);
    chk("after_clear_count", err_count, 9);
    chk("after_clear_count_w4", err_count4, 9);
    gen_word(w);
    step(1'b1, ~w, 1'b0);
    chk("pre_reset_locked", locked, 1);

    // Mid-stream reset while locked; relock with the same timing as before.
    areset();
    for (int i = 1; i <= 20; i++) begin
      gen_word(w);
      step(1'b1, ~w, 1'b0);
      if (i == 17) chk("relock_after_reset", locked, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
